// File: rtl/cfg_req_width_adapter.sv
// -----------------------------------------------------------------------------
// cfg_req_width_adapter
//
// Bridges one wide config request (UP_DW data) onto a narrow config target bus
// (DN_DW data) as up to RATIO = UP_DW/DN_DW sequential narrow requests. Beats
// whose byte-enable slice is all zero are skipped. The narrow acks are merged
// into a single wide ack: miss is OR-ed, SAI success is AND-ed, and read data
// is assembled lane by lane. A per-beat timeout turns a missing ack into a miss.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   up_req_*                   wide request (valid/ready handshake)
//   up_ack_*                   one-cycle merged wide ack
//   dn_req_*                   one-cycle narrow request per issued beat
//   dn_ack_*                   narrow ack (any valid/miss bit counts as an ack)
//   timeout_err                one-cycle pulse when a beat times out
//
// All outputs are registered. Only one wide transaction is in flight at a time.
// -----------------------------------------------------------------------------
module cfg_req_width_adapter #(
    parameter int unsigned UP_DW   = 64,
    parameter int unsigned DN_DW   = 32,
    parameter int unsigned ADDR_W  = 48,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 up_req_valid,
    output logic                 up_req_ready,
    input  logic [3:0]           up_req_opcode,
    input  logic [ADDR_W-1:0]    up_req_addr,
    input  logic [UP_DW/8-1:0]   up_req_be,
    input  logic [UP_DW-1:0]     up_req_data,
    input  logic [7:0]           up_req_sai,
    input  logic [7:0]           up_req_fid,
    input  logic [2:0]           up_req_bar,

    output logic                 up_ack_valid,
    output logic                 up_ack_read_valid,
    output logic                 up_ack_read_miss,
    output logic                 up_ack_write_valid,
    output logic                 up_ack_write_miss,
    output logic                 up_ack_sai_successfull,
    output logic [UP_DW-1:0]     up_ack_data,

    output logic                 dn_req_valid,
    output logic [3:0]           dn_req_opcode,
    output logic [ADDR_W-1:0]    dn_req_addr,
    output logic [DN_DW/8-1:0]   dn_req_be,
    output logic [DN_DW-1:0]     dn_req_data,
    output logic [7:0]           dn_req_sai,
    output logic [7:0]           dn_req_fid,
    output logic [2:0]           dn_req_bar,

    input  logic                 dn_ack_read_valid,
    input  logic                 dn_ack_read_miss,
    input  logic                 dn_ack_write_valid,
    input  logic                 dn_ack_write_miss,
    input  logic                 dn_ack_sai_successfull,
    input  logic [DN_DW-1:0]     dn_ack_data,

    output logic                 timeout_err
);

    localparam int unsigned RATIO  = UP_DW / DN_DW;
    localparam int unsigned UP_BE  = UP_DW / 8;
    localparam int unsigned DN_BE  = DN_DW / 8;
    localparam int unsigned DN_SH  = $clog2(DN_BE);
    localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    // Clears the byte-offset bits so beats start at the wide-aligned base.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(UP_BE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    // Captured request
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [UP_BE-1:0]  be_q, be_d;
    logic [UP_DW-1:0]  data_q, data_d;
    logic [7:0]        sai_q, sai_d;
    logic [7:0]        fid_q, fid_d;
    logic [2:0]        bar_q, bar_d;

    // Ack accumulators
    logic              acc_miss_q, acc_miss_d;
    logic              acc_sai_q, acc_sai_d;
    logic [UP_DW-1:0]  acc_data_q, acc_data_d;

    logic              is_rd;
    logic              last_beat;
    logic              ack_any;
    logic              beat_miss;
    logic              advance;
    logic              resp_fire;
    logic              timeout_fire;
    logic [DN_BE-1:0]  cur_be;

    // Next-beat view used to register the narrow request alongside the state
    logic [DN_BE-1:0]  nxt_be;
    logic [DN_DW-1:0]  nxt_data;
    logic [ADDR_W-1:0] nxt_addr;
    logic              dn_fire;

    assign is_rd     = ~op_q[0];
    assign last_beat = (beat_q == LAST_BEAT);
    assign ack_any   = dn_ack_read_valid | dn_ack_read_miss |
                       dn_ack_write_valid | dn_ack_write_miss;
    assign beat_miss = dn_ack_read_miss | dn_ack_write_miss;
    assign cur_be    = DN_BE'(be_q >> (32'(beat_q) * DN_BE));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        to_cnt_d     = to_cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        be_d         = be_q;
        data_d       = data_q;
        sai_d        = sai_q;
        fid_d        = fid_q;
        bar_d        = bar_q;
        acc_miss_d   = acc_miss_q;
        acc_sai_d    = acc_sai_q;
        acc_data_d   = acc_data_q;
        advance      = 1'b0;
        resp_fire    = 1'b0;
        timeout_fire = 1'b0;

        case (state_q)
            StIdle: begin
                // up_req_ready is the registered handshake output itself
                if (up_req_valid && up_req_ready) begin
                    op_d       = up_req_opcode;
                    addr_d     = up_req_addr;
                    be_d       = up_req_be;
                    data_d     = up_req_data;
                    sai_d      = up_req_sai;
                    fid_d      = up_req_fid;
                    bar_d      = up_req_bar;
                    beat_d     = '0;
                    acc_miss_d = 1'b0;
                    acc_sai_d  = 1'b1;
                    acc_data_d = '0;
                    state_d    = StIssue;
                end
            end

            StIssue: begin
                if (cur_be == '0) begin
                    // Empty slice: nothing to send, move on one beat per cycle
                    advance = 1'b1;
                end else begin
                    // The request pulse is already on the bus this cycle
                    to_cnt_d = '0;
                    state_d  = StWait;
                end
            end

            StWait: begin
                if (ack_any) begin
                    acc_miss_d = acc_miss_q | beat_miss;
                    acc_sai_d  = acc_sai_q & dn_ack_sai_successfull;
                    if (is_rd && !beat_miss) begin
                        acc_data_d = acc_data_q |
                                     (UP_DW'(dn_ack_data) << (32'(beat_q) * DN_DW));
                    end
                    advance = 1'b1;
                end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                    timeout_fire = 1'b1;
                    acc_miss_d   = 1'b1;
                    advance      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            StResp: begin
                resp_fire = 1'b1;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (last_beat) begin
                state_d = StResp;
            end else begin
                beat_d  = beat_q + BEAT_W'(1);
                state_d = StIssue;
            end
        end
    end

    // Narrow request for the beat the FSM is about to sit on, so dn_req_valid
    // is high exactly during the ISSUE cycle of a non-empty beat.
    always_comb begin
        nxt_be   = DN_BE'(be_d >> (32'(beat_d) * DN_BE));
        nxt_data = DN_DW'(data_d >> (32'(beat_d) * DN_DW));
        nxt_addr = (addr_d & ALIGN_MASK) + (ADDR_W'(beat_d) << DN_SH);
        dn_fire  = (state_d == StIssue) && (nxt_be != '0);
    end

    // -------------------------------------------------------------------------
    // State and captured request
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            to_cnt_q   <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            data_q     <= '0;
            sai_q      <= '0;
            fid_q      <= '0;
            bar_q      <= '0;
            acc_miss_q <= 1'b0;
            acc_sai_q  <= 1'b0;
            acc_data_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            to_cnt_q   <= to_cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            data_q     <= data_d;
            sai_q      <= sai_d;
            fid_q      <= fid_d;
            bar_q      <= bar_d;
            acc_miss_q <= acc_miss_d;
            acc_sai_q  <= acc_sai_d;
            acc_data_q <= acc_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            up_req_ready           <= 1'b0;
            up_ack_valid           <= 1'b0;
            up_ack_read_valid      <= 1'b0;
            up_ack_read_miss       <= 1'b0;
            up_ack_write_valid     <= 1'b0;
            up_ack_write_miss      <= 1'b0;
            up_ack_sai_successfull <= 1'b0;
            up_ack_data            <= '0;
            dn_req_valid           <= 1'b0;
            dn_req_opcode          <= '0;
            dn_req_addr            <= '0;
            dn_req_be              <= '0;
            dn_req_data            <= '0;
            dn_req_sai             <= '0;
            dn_req_fid             <= '0;
            dn_req_bar             <= '0;
            timeout_err            <= 1'b0;
        end else begin
            up_req_ready           <= (state_d == StIdle);

            up_ack_valid           <= resp_fire;
            up_ack_read_valid      <= resp_fire & is_rd & ~acc_miss_q;
            up_ack_read_miss       <= resp_fire & is_rd & acc_miss_q;
            up_ack_write_valid     <= resp_fire & ~is_rd & ~acc_miss_q;
            up_ack_write_miss      <= resp_fire & ~is_rd & acc_miss_q;
            up_ack_sai_successfull <= resp_fire & acc_sai_q;
            up_ack_data            <= (resp_fire && is_rd) ? acc_data_q : '0;

            dn_req_valid           <= dn_fire;
            dn_req_opcode          <= dn_fire ? op_d     : '0;
            dn_req_addr            <= dn_fire ? nxt_addr : '0;
            dn_req_be              <= dn_fire ? nxt_be   : '0;
            dn_req_data            <= dn_fire ? nxt_data : '0;
            dn_req_sai             <= dn_fire ? sai_d    : '0;
            dn_req_fid             <= dn_fire ? fid_d    : '0;
            dn_req_bar             <= dn_fire ? bar_d    : '0;

            timeout_err            <= timeout_fire;
        end
    end

endmodule

// File: tb/tb_cfg_req_width_adapter.sv
module tb_cfg_req_width_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_up_req_valid, b_up_req_valid;
    logic [3:0]  up_req_opcode;
    logic [47:0] up_req_addr;
    logic [7:0]  up_req_be;
    logic [63:0] up_req_data;
    logic [7:0]  up_req_sai, up_req_fid;
    logic [2:0]  up_req_bar;
    logic        dn_ack_read_valid, dn_ack_read_miss, dn_ack_write_valid, dn_ack_write_miss;
    logic        dn_ack_sai_successfull;
    logic [31:0] dn_ack_data;

    // DUT A: 64 -> 32, TIMEOUT = 4
    logic        a_up_req_ready, a_up_ack_valid, a_rv, a_rm, a_wv, a_wm, a_sai;
    logic [63:0] a_up_ack_data;
    logic        a_dn_req_valid;
    logic [3:0]  a_dn_req_opcode;
    logic [47:0] a_dn_req_addr;
    logic [3:0]  a_dn_req_be;
    logic [31:0] a_dn_req_data;
    logic [7:0]  a_dn_req_sai, a_dn_req_fid;
    logic [2:0]  a_dn_req_bar;
    logic        a_timeout_err;

    // DUT B: 64 -> 8
    logic        b_up_req_ready, b_up_ack_valid, b_rv, b_rm, b_wv, b_wm, b_sai;
    logic [63:0] b_up_ack_data;
    logic        b_dn_req_valid;
    logic [3:0]  b_dn_req_opcode;
    logic [47:0] b_dn_req_addr;
    logic [0:0]  b_dn_req_be;
    logic [7:0]  b_dn_req_data;
    logic [7:0]  b_dn_req_sai, b_dn_req_fid;
    logic [2:0]  b_dn_req_bar;
    logic        b_timeout_err;

    cfg_req_width_adapter #(.UP_DW(64), .DN_DW(32), .ADDR_W(48), .TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset),
        .up_req_valid(a_up_req_valid), .up_req_ready(a_up_req_ready),
        .up_req_opcode(up_req_opcode), .up_req_addr(up_req_addr), .up_req_be(up_req_be),
        .up_req_data(up_req_data), .up_req_sai(up_req_sai), .up_req_fid(up_req_fid),
        .up_req_bar(up_req_bar),
        .up_ack_valid(a_up_ack_valid), .up_ack_read_valid(a_rv), .up_ack_read_miss(a_rm),
        .up_ack_write_valid(a_wv), .up_ack_write_miss(a_wm),
        .up_ack_sai_successfull(a_sai), .up_ack_data(a_up_ack_data),
        .dn_req_valid(a_dn_req_valid), .dn_req_opcode(a_dn_req_opcode),
        .dn_req_addr(a_dn_req_addr), .dn_req_be(a_dn_req_be), .dn_req_data(a_dn_req_data),
        .dn_req_sai(a_dn_req_sai), .dn_req_fid(a_dn_req_fid), .dn_req_bar(a_dn_req_bar),
        .dn_ack_read_valid(dn_ack_read_valid), .dn_ack_read_miss(dn_ack_read_miss),
        .dn_ack_write_valid(dn_ack_write_valid), .dn_ack_write_miss(dn_ack_write_miss),
        .dn_ack_sai_successfull(dn_ack_sai_successfull), .dn_ack_data(dn_ack_data),
        .timeout_err(a_timeout_err)
    );

    cfg_req_width_adapter #(.UP_DW(64), .DN_DW(8), .ADDR_W(48), .TIMEOUT(255)) dut_b (
        .clk(clk), .reset(reset),
        .up_req_valid(b_up_req_valid), .up_req_ready(b_up_req_ready),
        .up_req_opcode(up_req_opcode), .up_req_addr(up_req_addr), .up_req_be(up_req_be),
        .up_req_data(up_req_data), .up_req_sai(up_req_sai), .up_req_fid(up_req_fid),
        .up_req_bar(up_req_bar),
        .up_ack_valid(b_up_ack_valid), .up_ack_read_valid(b_rv), .up_ack_read_miss(b_rm),
        .up_ack_write_valid(b_wv), .up_ack_write_miss(b_wm),
        .up_ack_sai_successfull(b_sai), .up_ack_data(b_up_ack_data),
        .dn_req_valid(b_dn_req_valid), .dn_req_opcode(b_dn_req_opcode),
        .dn_req_addr(b_dn_req_addr), .dn_req_be(b_dn_req_be), .dn_req_data(b_dn_req_data),
        .dn_req_sai(b_dn_req_sai), .dn_req_fid(b_dn_req_fid), .dn_req_bar(b_dn_req_bar),
        .dn_ack_read_valid(dn_ack_read_valid), .dn_ack_read_miss(dn_ack_read_miss),
        .dn_ack_write_valid(dn_ack_write_valid), .dn_ack_write_miss(dn_ack_write_miss),
        .dn_ack_sai_successfull(dn_ack_sai_successfull), .dn_ack_data(dn_ack_data[7:0]),
        .timeout_err(b_timeout_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Selects which DUT the transaction helper drives and observes
    logic use8;
    logic m_ready, m_ack_valid, m_req_valid, m_to;
    always_comb begin
        m_ready     = use8 ? b_up_req_ready : a_up_req_ready;
        m_ack_valid = use8 ? b_up_ack_valid : a_up_ack_valid;
        m_req_valid = use8 ? b_dn_req_valid : a_dn_req_valid;
        m_to        = use8 ? b_timeout_err  : a_timeout_err;
    end

    // Target responses, indexed by narrow request number
    logic [31:0] rsp_data   [16];
    logic        rsp_miss   [16];
    logic        rsp_sai    [16];
    logic        rsp_silent [16];

    // Observed traffic
    logic [47:0] req_addr [16];
    logic [3:0]  req_be   [16];
    logic [31:0] req_data [16];
    logic [3:0]  rec_op;
    logic [7:0]  rec_sai, rec_fid;
    logic [2:0]  rec_bar;
    int          n_req, n_to, to_t, ack_t;
    logic        got_ack;
    logic        ak_rv, ak_rm, ak_wv, ak_wm, ak_sai;
    logic [63:0] ak_data;
    logic [63:0] exp64;
    int          spurious;

    task automatic rsp_default();
        for (int i = 0; i < 16; i++) begin
            rsp_data[i]   = 32'h0;
            rsp_miss[i]   = 1'b0;
            rsp_sai[i]    = 1'b1;
            rsp_silent[i] = 1'b0;
        end
    endtask

    task automatic clear_acks();
        dn_ack_read_valid      = 1'b0;
        dn_ack_read_miss       = 1'b0;
        dn_ack_write_valid     = 1'b0;
        dn_ack_write_miss      = 1'b0;
        dn_ack_sai_successfull = 1'b0;
        dn_ack_data            = 32'h0;
    endtask

    // Issues one wide request and plays a target that acks each narrow request
    // one cycle after it appears. t counts posedges since the accept edge.
    task automatic run_txn(input string nm, input logic [3:0] op, input logic [47:0] addr,
                           input logic [7:0] be, input logic [63:0] data);
        int t;
        int ack_at;
        int ack_idx;
        n_req = 0; n_to = 0; to_t = -1; ack_t = -1; got_ack = 1'b0;
        ack_at = -1; ack_idx = 0;
        up_req_opcode = op; up_req_addr = addr; up_req_be = be; up_req_data = data;
        check({nm, "_ready_idle"}, 64'(m_ready), 64'd1);
        if (use8) b_up_req_valid = 1'b1;
        else      a_up_req_valid = 1'b1;
        @(negedge clk);
        a_up_req_valid = 1'b0;
        b_up_req_valid = 1'b0;
        check({nm, "_ready_drop"}, 64'(m_ready), 64'd0);
        t = 0;
        while (t < 60 && !got_ack) begin
            clear_acks();
            if (t == ack_at) begin
                if (op[0]) begin
                    dn_ack_write_valid = ~rsp_miss[ack_idx];
                    dn_ack_write_miss  = rsp_miss[ack_idx];
                end else begin
                    dn_ack_read_valid  = ~rsp_miss[ack_idx];
                    dn_ack_read_miss   = rsp_miss[ack_idx];
                end
                dn_ack_sai_successfull = rsp_sai[ack_idx];
                dn_ack_data            = rsp_data[ack_idx];
            end
            if (m_req_valid && n_req < 16) begin
                req_addr[n_req] = use8 ? b_dn_req_addr : a_dn_req_addr;
                req_be[n_req]   = use8 ? {3'b000, b_dn_req_be} : a_dn_req_be;
                req_data[n_req] = use8 ? {24'h0, b_dn_req_data} : a_dn_req_data;
                if (n_req == 0) begin
                    rec_op  = use8 ? b_dn_req_opcode : a_dn_req_opcode;
                    rec_sai = use8 ? b_dn_req_sai : a_dn_req_sai;
                    rec_fid = use8 ? b_dn_req_fid : a_dn_req_fid;
                    rec_bar = use8 ? b_dn_req_bar : a_dn_req_bar;
                end
                if (!rsp_silent[n_req]) begin
                    ack_at  = t + 1;
                    ack_idx = n_req;
                end
                n_req++;
            end
            if (m_to) begin
                n_to++;
                to_t = t;
            end
            if (m_ack_valid) begin
                got_ack = 1'b1;
                ack_t   = t;
                ak_rv   = use8 ? b_rv  : a_rv;
                ak_rm   = use8 ? b_rm  : a_rm;
                ak_wv   = use8 ? b_wv  : a_wv;
                ak_wm   = use8 ? b_wm  : a_wm;
                ak_sai  = use8 ? b_sai : a_sai;
                ak_data = use8 ? b_up_ack_data : a_up_ack_data;
            end
            @(negedge clk);
            t++;
        end
        clear_acks();
        check({nm, "_got_ack"}, 64'(got_ack), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        use8 = 1'b0;
        reset = 1'b1;
        a_up_req_valid = 1'b0; b_up_req_valid = 1'b0;
        up_req_opcode = 4'h0; up_req_addr = 48'h0; up_req_be = 8'h0; up_req_data = 64'h0;
        up_req_sai = 8'h5A; up_req_fid = 8'h21; up_req_bar = 3'd3;
        clear_acks();
        rsp_default();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready_a", 64'(a_up_req_ready), 64'd0);
        check("rst_ready_b", 64'(b_up_req_ready), 64'd0);
        check("rst_ack_valid", 64'(a_up_ack_valid), 64'd0);
        check("rst_dn_valid", 64'(a_dn_req_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 64'(a_up_req_ready), 64'd1);
        check("post_rst_ready_b", 64'(b_up_req_ready), 64'd1);

        // T1: full-width read, two beats
        rsp_default();
        rsp_data[0] = 32'hAAAA0000;
        rsp_data[1] = 32'h5555FFFF;
        run_txn("t1", 4'h0, 48'h1004, 8'hFF, 64'h0);
        check("t1_nreq", 64'(n_req), 64'd2);
        check("t1_addr0", 64'(req_addr[0]), 64'h1000);
        check("t1_addr1", 64'(req_addr[1]), 64'h1004);
        check("t1_be0", 64'(req_be[0]), 64'hF);
        check("t1_be1", 64'(req_be[1]), 64'hF);
        check("t1_lat", 64'(ack_t), 64'd5);
        check("t1_rv", 64'(ak_rv), 64'd1);
        check("t1_rm", 64'(ak_rm), 64'd0);
        check("t1_wv", 64'(ak_wv), 64'd0);
        check("t1_sai", 64'(ak_sai), 64'd1);
        check("t1_data", ak_data, 64'h5555FFFF_AAAA0000);

        // T2: write with only the upper half enabled
        rsp_default();
        run_txn("t2", 4'h1, 48'h2000, 8'hF0, 64'h11223344_55667788);
        check("t2_nreq", 64'(n_req), 64'd1);
        check("t2_addr", 64'(req_addr[0]), 64'h2004);
        check("t2_be", 64'(req_be[0]), 64'hF);
        check("t2_wdata", 64'(req_data[0]), 64'h11223344);
        check("t2_op", 64'(rec_op), 64'h1);
        check("t2_dn_sai", 64'(rec_sai), 64'h5A);
        check("t2_dn_fid", 64'(rec_fid), 64'h21);
        check("t2_dn_bar", 64'(rec_bar), 64'd3);
        check("t2_lat", 64'(ack_t), 64'd4);
        check("t2_wv", 64'(ak_wv), 64'd1);
        check("t2_wm", 64'(ak_wm), 64'd0);
        check("t2_rv", 64'(ak_rv), 64'd0);
        check("t2_data", ak_data, 64'h0);

        // T3: read where the second beat misses and fails SAI
        rsp_default();
        rsp_data[0] = 32'hDEADBEEF;
        rsp_data[1] = 32'hFFFFFFFF;
        rsp_miss[1] = 1'b1;
        rsp_sai[1]  = 1'b0;
        run_txn("t3", 4'h4, 48'h3000, 8'hFF, 64'h0);
        check("t3_rm", 64'(ak_rm), 64'd1);
        check("t3_rv", 64'(ak_rv), 64'd0);
        check("t3_sai", 64'(ak_sai), 64'd0);
        check("t3_data", ak_data, 64'h00000000_DEADBEEF);

        // T4: target silent on beat 0, timeout forces a miss
        rsp_default();
        rsp_silent[0] = 1'b1;
        rsp_data[1]   = 32'h12345678;
        run_txn("t4", 4'h0, 48'h4000, 8'hFF, 64'h0);
        check("t4_nto", 64'(n_to), 64'd1);
        check("t4_to_time", 64'(to_t), 64'd5);
        check("t4_nreq", 64'(n_req), 64'd2);
        check("t4_addr1", 64'(req_addr[1]), 64'h4004);
        check("t4_lat", 64'(ack_t), 64'd8);
        check("t4_rm", 64'(ak_rm), 64'd1);
        check("t4_rv", 64'(ak_rv), 64'd0);
        check("t4_sai", 64'(ak_sai), 64'd1);
        check("t4_data", ak_data, 64'h12345678_00000000);

        // T5: all-zero byte enables
        rsp_default();
        run_txn("t5", 4'h0, 48'h5000, 8'h00, 64'h0);
        check("t5_nreq", 64'(n_req), 64'd0);
        check("t5_lat", 64'(ack_t), 64'd3);
        check("t5_rv", 64'(ak_rv), 64'd1);
        check("t5_rm", 64'(ak_rm), 64'd0);
        check("t5_sai", 64'(ak_sai), 64'd1);
        check("t5_data", ak_data, 64'h0);

        // T6: reset while waiting for an ack
        up_req_opcode = 4'h0; up_req_addr = 48'h1004; up_req_be = 8'hFF;
        a_up_req_valid = 1'b1;
        @(negedge clk);
        a_up_req_valid = 1'b0;
        check("t6_req_issued", 64'(a_dn_req_valid), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", 64'(a_up_req_ready), 64'd0);
        check("t6_rst_ack", 64'(a_up_ack_valid), 64'd0);
        check("t6_rst_dn", 64'(a_dn_req_valid), 64'd0);
        check("t6_rst_dnaddr", 64'(a_dn_req_addr), 64'h0);
        check("t6_rst_data", a_up_ack_data, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_ready_back", 64'(a_up_req_ready), 64'd1);
        spurious = 0;
        repeat (6) begin
            if (a_up_ack_valid || a_dn_req_valid || a_timeout_err) spurious++;
            @(negedge clk);
        end
        check("t6_no_ack", 64'(spurious), 64'd0);
        rsp_default();
        rsp_data[0] = 32'h0BADF00D;
        rsp_data[1] = 32'hCAFEBABE;
        run_txn("t6b", 4'h0, 48'h1008, 8'hFF, 64'h0);
        check("t6b_addr0", 64'(req_addr[0]), 64'h1008);
        check("t6b_lat", 64'(ack_t), 64'd5);
        check("t6b_rv", 64'(ak_rv), 64'd1);
        check("t6b_data", ak_data, 64'hCAFEBABE_0BADF00D);

        // T7: 64 -> 8 bridge, eight byte beats
        use8 = 1'b1;
        rsp_default();
        exp64 = 64'h5555FFFF_AAAA0000;
        for (int i = 0; i < 8; i++) rsp_data[i] = {24'h0, exp64[8*i +: 8]};
        run_txn("t7", 4'h0, 48'h1004, 8'hFF, 64'h0);
        check("t7_nreq", 64'(n_req), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t7_addr%0d", i), 64'(req_addr[i]), 64'h1000 + 64'(i));
            check($sformatf("t7_be%0d", i), 64'(req_be[i]), 64'h1);
        end
        check("t7_lat", 64'(ack_t), 64'd17);
        check("t7_rv", 64'(ak_rv), 64'd1);
        check("t7_data", ak_data, 64'h5555FFFF_AAAA0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
